result_display: RTL and testbench
=================================

# result_display

Downstream display stage for the ALU result bus. It takes the signed 8-bit ALU result `Y` and converts its magnitude to three BCD digits with a sequential double-dabble engine. It then drives a 4-digit common-anode seven-segment display, time-multiplexed, showing a sign digit and three decimal digits. It sits between the ALU output register and the board display pins, clocked from the same divided clock as the ALU.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit. Legal range is ≥2.
- `clock` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high. All state clears immediately when asserted.
- `value` input, 8 bits: signed two's-complement result to display (ALU `Y`).
- `seg` output, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.
- `an` output, 4 bits: active-low digit enables. `an[0]` is ones, `an[1]` tens, `an[2]` hundreds, `an[3]` sign.
- `busy` output, 1 bit: high while a conversion is in progress.

## Operation
- **Registers**
  - `captured[7:0]`: last value accepted for conversion.
  - `mag[7:0]`: shift source.
  - `bcd[11:0]`: working register.
  - `iter[2:0]`: shift counter.
  - Display registers: `neg`, `hun[3:0]`, `ten[3:0]`, `one[3:0]`.
  - `refresh` counter and `dig[1:0]`.
- **Reset values:** all of the above are 0, FSM is in IDLE, `busy`=0, `an`=4'b1110, `seg`=7'h40 (shows "0").
- **FSM has three states: IDLE, SHIFT, COMMIT.**
- **IDLE**
  - If `value != captured` at a clock edge: load `captured<=value`, `neg<=value[7]`-to-be-committed (held in a shadow bit), `mag<=value[7] ? (~value+1) : value`, `bcd<=0`, `iter<=0`, then go to SHIFT.
  - Magnitude is unsigned 0..128. -128 (8'h80) yields `mag`=8'h80=128.
  - Otherwise stay in IDLE.
- **SHIFT:** runs exactly 8 cycles. Each cycle does the following:
  - Add 3 to every `bcd` nibble ≥5.
  - Shift {`bcd`,`mag`} left by 1.
  - Increment `iter`.
  - Leave for COMMIT when `iter`==7.
- **COMMIT:** in one cycle, copy `bcd` into `hun`/`ten`/`one` and the shadow sign into `neg` atomically, then return to IDLE. Digits never show partial results.
- **Changes to `value` during SHIFT/COMMIT** are ignored. On return to IDLE the input is compared against `captured` again, so the final stable value is always displayed eventually.
- **Digit decode**, values 0-9 (active-low): 40,79,24,30,19,12,02,78,00,10 hex. Blank is 7F; minus is 3F.
- **Digit rules**
  - Sign digit: minus if `neg`, else blank.
  - Hundreds: blank if `hun`==0.
  - Tens: blank if `hun`==0 and `ten`==0.
  - Ones: always shown.
- **Refresh**
  - `refresh` counts 0..REFRESH_DIV-1.
  - On terminal count it wraps to 0 and `dig` increments mod 4.
  - `an` is ~(1<<`dig`), decoded combinationally from registers.
  - `seg` is the decode of the digit selected by `dig`.
- **Independence:** the refresh logic runs independently of the FSM and never stalls.

## Timing
- **Latency:** if `value` changes and is sampled in IDLE at edge N, then `busy` is high after edge N and SHIFT occupies edges N+1..N+8. Display registers update at edge N+9 and `busy` falls after edge N+9. Total latency is 9 cycles from sample to new digits.
- **Back-to-back changes:** earliest next capture is edge N+10.
- **Refresh period:** each digit is lit for exactly REFRESH_DIV cycles, so a full frame is 4×REFRESH_DIV cycles.
- **Output stability:** `an`/`seg` change only on edges where `dig` or the display registers change, and COMMIT can occur in any refresh phase.
- **Reset mid-conversion:** the FSM aborts to IDLE and the display reverts to "0" immediately (asynchronously). After release, a nonzero `value` starts a fresh conversion on the first edge.
- **Unchanged value:** `value` equal to `captured` triggers no conversion, including `value`=0 right after reset.

## Test plan
- **Reset:** assert `reset` mid-frame → `an`=1110, `seg`=40, `busy`=0 immediately. Hold `value`=0 after release → `busy` never rises.
- **Positive value:** `value`=127, REFRESH_DIV=4 → `busy` high for 9 cycles, then over one frame digits read ones=78('7'), tens=24('2'), hundreds=79('1'), sign=7F.
- **Most-negative value:** `value`=8'h80 (-128) → ones=00('8'), tens=24, hundreds=79, sign=3F.
- **Leading-zero blanking:** `value`=-5 (8'hFB) → ones=12('5'), tens=7F, hundreds=7F, sign=3F. Then `value`=10 → ones=40, tens=79, hundreds=7F, sign=7F.
- **Change during conversion:** `value`=42, then 99 three cycles later → 42 commits at edge N+9, 99 is captured at edge N+10 and commits at edge N+19, and `busy` drops for exactly one cycle between the two conversions.
- **Refresh sequencing and reset mid-SHIFT:** REFRESH_DIV=4 → `an` sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wrapping. Reset asserted during SHIFT → no commit occurs, the display reads "0", and after release the held `value` reconverts in 9 cycles.

Source files
------------

// File: rtl/result_display.sv
// result_display: signed 8-bit result to a sign + three-digit decimal readout
// on a time-multiplexed 4-digit common-anode seven-segment display.
// A sequential double-dabble engine converts the magnitude. The refresh
// scanner runs on its own and never waits for a conversion.
module result_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int unsigned       RW           = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0]     REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [6:0]        SEG_BLANK    = 7'h7F;
    localparam logic [6:0]        SEG_MINUS    = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t      state;
    logic [7:0]  captured;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic [2:0]  iter;
    logic        neg_shadow;
    logic        neg;
    logic [3:0]  hun;
    logic [3:0]  ten;
    logic [3:0]  one;
    logic [RW-1:0] refresh;
    logic [1:0]  dig;
    logic [11:0] bcd_adj_c;

    // Active-low segment pattern for a decimal digit; anything else blanks.
    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble of 5 or more.
    always_comb begin
        bcd_adj_c = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: capture on change, eight shift steps, atomic commit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            captured   <= 8'd0;
            mag        <= 8'd0;
            bcd        <= 12'd0;
            iter       <= 3'd0;
            neg_shadow <= 1'b0;
            neg        <= 1'b0;
            hun        <= 4'd0;
            ten        <= 4'd0;
            one        <= 4'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (value != captured) begin
                        captured   <= value;
                        neg_shadow <= value[7];
                        // -128 negates to itself, which reads as 128 unsigned
                        mag        <= value[7] ? 8'(~value + 8'd1) : value;
                        bcd        <= 12'd0;
                        iter       <= 3'd0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= {bcd_adj_c[10:0], mag[7]};
                    mag  <= {mag[6:0], 1'b0};
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    neg   <= neg_shadow;
                    hun   <= bcd[11:8];
                    ten   <= bcd[7:4];
                    one   <= bcd[3:0];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Refresh scanner: each digit stays lit for REFRESH_DIV cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh <= '0;
            dig     <= 2'd0;
        end else if (refresh == REFRESH_LAST) begin
            refresh <= '0;
            dig     <= dig + 2'd1;
        end else begin
            refresh <= refresh + RW'(1);
        end
    end

    // Anode select decoded straight from the scan register.
    assign an = ~(4'b0001 << dig);

    // Segment select with sign and leading-zero blanking.
    always_comb begin
        seg = SEG_BLANK;
        case (dig)
            2'd0: seg = decode_digit(one);
            2'd1: seg = (hun == 4'd0 && ten == 4'd0) ? SEG_BLANK : decode_digit(ten);
            2'd2: seg = (hun == 4'd0) ? SEG_BLANK : decode_digit(hun);
            2'd3: seg = neg ? SEG_MINUS : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: directed and random values against a decimal
// arithmetic reference model of the readout and the refresh scan.
module tb_result_display;

    localparam int unsigned DIV = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         ncyc     = 0;
    logic [7:0] shown;

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clock (clock),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    // Edges seen since reset released; the scan position follows from it.
    always @(posedge clock or posedge reset) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    function automatic logic [6:0] dig7(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected segments of display position pos (0 ones .. 3 sign) for v.
    function automatic logic [6:0] exp_seg(input logic [7:0] v, input int pos);
        int sv, m, h, t, o;
        sv = int'($signed(v));
        m  = (sv < 0) ? -sv : sv;
        h  = m / 100;
        t  = (m / 10) % 10;
        o  = m % 10;
        case (pos)
            0: return dig7(o);
            1: return (h == 0 && t == 0) ? 7'h7F : dig7(t);
            2: return (h == 0) ? 7'h7F : dig7(h);
            default: return (sv < 0) ? 7'h3F : 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare an/seg for the current scan position against value v.
    task automatic check_now(input logic [7:0] v, input string tag);
        int         pos;
        logic [3:0] exp_an;
        pos    = (ncyc / DIV) % 4;
        exp_an = ~(4'b0001 << pos);
        check({tag, "_an"}, 32'(an), 32'(exp_an));
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg(v, pos)));
    endtask

    task automatic check_frame(input logic [7:0] v, input string tag);
        repeat (4 * DIV) begin
            @(negedge clock);
            check_now(v, tag);
        end
    endtask

    // Busy over the ten edges following a sample edge.
    task automatic busy_seq(input logic exp_busy, input string tag);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check({tag, "_busy"}, 32'(busy), (i < 9) ? 32'(exp_busy) : 32'd0);
        end
    endtask

    task automatic apply(input logic [7:0] v, input string tag);
        logic conv;
        conv = (v != shown);
        @(negedge clock);
        value = v;
        busy_seq(conv, tag);
        shown = v;
        check_frame(v, tag);
    endtask

    initial begin
        reset = 1'b1;
        value = 8'd0;
        shown = 8'd0;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check_now(8'd0, "rst");
        reset = 1'b0;

        // Reset mid-frame, then value 0 must never start a conversion.
        repeat (6) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rstmid_an", 32'(an), 32'h0E);
        check("rstmid_seg", 32'(seg), 32'h40);
        check("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("zero_busy", 32'(busy), 32'd0);
            check_now(8'd0, "zero");
        end

        // Directed values covering positive, -128 and blanking.
        apply(8'd127, "p127");
        apply(8'h80, "m128");
        apply(8'hFB, "m5");
        apply(8'd10, "p10");
        apply(8'd10, "same10");

        // Change during conversion: 42 then 99 three cycles later.
        @(negedge clock);
        value = 8'd42;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 2) value = 8'd99;
            check("b2b_busy", 32'(busy), (i == 9 || i == 19) ? 32'd0 : 32'd1);
            if (i == 9 || i == 18) check_now(8'd42, "b2b42");
            if (i == 8) check_now(8'd10, "b2bold");
            if (i == 19) check_now(8'd99, "b2b99");
        end
        shown = 8'd99;
        check_frame(8'd99, "b2bframe");

        // Reset during SHIFT: no commit, display back to 0, then reconvert.
        @(negedge clock);
        value = 8'd77;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rstshift_an", 32'(an), 32'h0E);
        check("rstshift_seg", 32'(seg), 32'h40);
        check("rstshift_busy", 32'(busy), 32'd0);
        @(negedge clock);
        shown = 8'd0;
        reset = 1'b0;
        busy_seq(1'b1, "reconv");
        shown = 8'd77;
        check_frame(8'd77, "reconv");

        // Random values, with periodic repeats of the shown value.
        for (int k = 0; k < 14; k++) begin
            logic [7:0] v;
            v = (k % 4 == 3) ? shown : 8'($urandom_range(0, 255));
            apply(v, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
